ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter; the opposite direction to the existing PS/2 keyboard receiver on `ps2Clk`/`ps2Data`.
- Lets the CPU or OSD logic send command bytes to the keyboard: LED set `0xED`, reset `0xFF`, typematic `0xF3`.
- Drives both PS/2 lines open-drain; the top level does `ps2Clk = clk_oe ? 0 : z`, and likewise for data.
- Coexists with the receiver: transmits only when the bus is idle, then releases both lines.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_tx.sv | 157 +++++++++++++++
 tb/tb_ps2_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and helpers for the host-side transmitter (and receiver).
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE,
    FAIL
  } ps2_tx_state_t;

  // Whole-MHz clock assumed: cycles = (Hz / 1e6) * us
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 32'd1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchroniser for the raw PS/2 clock/data pins plus a clock falling-edge
// strobe. Idle level of both lines is 1, so reset loads 1s.
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Two-stage synchronisers plus one history bit for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_i};
      data_ff  <= {data_ff[0], data_i};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s    = clk_ff[1];
  assign data_s   = data_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. Inhibits the clock, issues request-to-send,
// shifts a byte + odd parity out on device clock falling edges, checks the ACK.
// Both lines are open-drain: *_oe = 1 pulls the line low.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to c_retries times
// before reporting tx_error.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned c_clk_hz     = 25000000,
  parameter int unsigned c_inhibit_us = 100,
  parameter int unsigned c_timeout_us = 15000,
  parameter int unsigned c_retries    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(c_clk_hz, c_inhibit_us);
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(c_clk_hz, c_timeout_us);
  localparam int IH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  ps2_tx_state_t   state, state_nxt;
  logic [IH_W-1:0] inh_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      shreg;
  logic            parity;
  logic [3:0]      bitcnt;
  logic            data_drv;
  logic            ack_flag;
  logic            clk_s, data_s, clk_fall;
  logic            bus_idle, inh_last, to_hit, accept, in_frame, retry_left;

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_i    (ps2_clk_i),
    .data_i   (ps2_data_i),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  assign bus_idle = clk_s & data_s;
  assign inh_last = (inh_cnt == IH_W'(INHIBIT_CYC - 1));
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign accept   = tx_valid & tx_ready;
  assign in_frame = (state == REQ) || (state == DATA) || (state == PARITY) || (state == ACK);

`ifdef PS2_TX_RETRY_EN
  logic [7:0] retry_cnt;
  assign retry_left = (retry_cnt < 8'(c_retries));

  // Failed attempts for the current byte; a new byte starts a fresh budget
  always_ff @(posedge clk) begin
    if (!reset_n)
      retry_cnt <= '0;
    else if (accept)
      retry_cnt <= '0;
    else if (state == WAIT_IDLE && bus_idle && !ack_flag && retry_left)
      retry_cnt <= retry_cnt + 8'd1;
  end
`else
  // Retries compiled out: any failure ends the request
  assign retry_left = 1'b0 && (c_retries != 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: the frame timeout spans REQ..ACK and outranks any clock edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = INHIBIT;
      INHIBIT:   if (inh_last) state_nxt = REQ;
      REQ:       if (to_hit) state_nxt = FAIL;
                 else if (clk_fall) state_nxt = DATA;
      DATA:      if (to_hit) state_nxt = FAIL;
                 else if (clk_fall && bitcnt == 4'(PS2_DATA_BITS)) state_nxt = PARITY;
      PARITY:    if (to_hit) state_nxt = FAIL;
                 else if (clk_fall) state_nxt = ACK;
      ACK:       if (to_hit) state_nxt = FAIL;
                 else if (clk_fall) state_nxt = data_s ? FAIL : WAIT_IDLE;
      WAIT_IDLE: if (bus_idle) state_nxt = (ack_flag || !retry_left) ? IDLE : INHIBIT;
      FAIL:      state_nxt = WAIT_IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs: pulses fire in the last WAIT_IDLE cycle so tx_ready rises a cycle later
  always_comb begin
    tx_ready    = (state == IDLE) && bus_idle;
    ps2_clk_oe  = (state == INHIBIT);
    ps2_data_oe = 1'b0;
    case (state)
      INHIBIT:           ps2_data_oe = inh_last;
      REQ:               ps2_data_oe = 1'b1;
      DATA, PARITY, ACK: ps2_data_oe = data_drv;
      default:           ps2_data_oe = 1'b0;
    endcase
    tx_done  = (state == WAIT_IDLE) && bus_idle && ack_flag;
    tx_error = (state == WAIT_IDLE) && bus_idle && !ack_flag && !retry_left;
  end

  // Datapath: byte latch, timers, bit presentation on falling edges, ACK flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inh_cnt  <= '0;
      to_cnt   <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      bitcnt   <= '0;
      data_drv <= 1'b0;
      ack_flag <= 1'b0;
    end else begin
      inh_cnt <= (state == INHIBIT) ? inh_cnt + IH_W'(1) : '0;
      to_cnt  <= in_frame ? to_cnt + TO_W'(1) : '0;
      if (accept) begin
        shreg  <= tx_data;
        parity <= ~^tx_data;
      end
      case (state)
        INHIBIT: ack_flag <= 1'b0;
        REQ: if (clk_fall && !to_hit) begin
          data_drv <= ~shreg[0];
          bitcnt   <= 4'd1;
        end
        DATA: if (clk_fall && !to_hit) begin
          if (bitcnt == 4'(PS2_DATA_BITS)) begin
            data_drv <= ~parity;
          end else begin
            data_drv <= ~shreg[bitcnt[2:0]];
            bitcnt   <= bitcnt + 4'd1;
          end
        end
        PARITY: if (clk_fall && !to_hit) data_drv <= 1'b0;
        ACK:    if (clk_fall && !to_hit) ack_flag <= ~data_s;
        FAIL:   ack_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 keyboard drives the open-drain lines,
// frames are compared against bit lists built from the byte value.
module tb_ps2_tx;

  localparam int unsigned CLK_HZ  = 25000000;
  localparam int unsigned INH_US  = 100;
  localparam int unsigned TO_US   = 10;
  localparam int unsigned RETRIES = 2;
  localparam int INH_CYC_EXP = (CLK_HZ / 1000000) * INH_US;  // 2500
  localparam int TO_CYC_EXP  = (CLK_HZ / 1000000) * TO_US;   // 250
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = RETRIES + 1;
`else
  localparam int ATTEMPTS = 1;
`endif
  localparam int H = 8;  // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int excl_bad = 0;

  // Wired-AND open-drain bus
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(
    .c_clk_hz     (CLK_HZ),
    .c_inhibit_us (INH_US),
    .c_timeout_us (TO_US),
    .c_retries    (RETRIES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
    if ((tx_done && tx_error) || ((tx_done || tx_error) && tx_ready)) excl_bad++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog");
  end

  // Expected line bits, index = order on the wire: 8 data LSB first, parity, stop
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic send(input logic [7:0] d, output bit acc);
    int n;
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1; n = 0;
    while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
    acc = tx_ready;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard side of one host-to-device frame
  task automatic dev_frame(input bit ack, output logic [9:0] bits, output int inh,
                           output bit start_ok, output bit seen);
    int n;
    bits = '0; inh = 0; start_ok = 1'b0; seen = 1'b0; n = 0;
    while (!ps2_clk_oe && n < 20000) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) return;
    seen = 1'b1;
    while (ps2_clk_oe && inh < 100000) begin inh++; @(negedge clk); end
    start_ok = (ps2_data_i == 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[i] = ps2_data_i;
      repeat (H) @(negedge clk);
    end
    if (ack) dev_data_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic wait_pulse(output bit gd, output bit ge, output bit rdy_after);
    int n;
    n = 0;
    while (!(tx_done || tx_error) && n < 1000) begin @(negedge clk); n++; end
    gd = tx_done; ge = tx_error;
    @(negedge clk);
    rdy_after = tx_ready && !tx_done && !tx_error;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    total++; if ({tx_done, tx_error} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {tx_done, tx_error}); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_frame(input logic [7:0] d, input string nm);
    logic [9:0] bits;
    int inh, d0, e0;
    bit st, seen, acc, gd, ge, ra;
    d0 = done_cnt; e0 = err_cnt;
    fork
      send(d, acc);
      dev_frame(1'b1, bits, inh, st, seen);
    join
    wait_pulse(gd, ge, ra);
    repeat (4) @(negedge clk);
    total++; if ({acc, seen, st} !== 3'b111) begin bad++; $display("FAIL %s accept/seen/start: got %b want 111", nm, {acc, seen, st}); end
    total++; if (inh !== INH_CYC_EXP) begin bad++; $display("FAIL %s inhibit: got %0d want %0d", nm, inh, INH_CYC_EXP); end
    total++; if (bits !== frame_model(d)) begin bad++; $display("FAIL %s bits(stop,par,d7..d0): got %b want %b", nm, bits, frame_model(d)); end
    total++; if ({gd, ge} !== 2'b10) begin bad++; $display("FAIL %s done/err: got %b want 10", nm, {gd, ge}); end
    total++; if (ra !== 1'b1) begin bad++; $display("FAIL %s ready_after: got %b want 1", nm, ra); end
    total++; if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin bad++; $display("FAIL %s pulse_counts: got done+%0d err+%0d want +1 +0", nm, done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_timeout();
    int e0, d0, seen, lat;
    bit acc, oe_ok;
    e0 = err_cnt; d0 = done_cnt; seen = 0; lat = -1; oe_ok = 1'b0;
    fork
      send(8'h5A, acc);
      begin
        int n;
        for (int a = 0; a < ATTEMPTS; a++) begin
          n = 0;
          while (!ps2_clk_oe && n < 20000) begin @(negedge clk); n++; end
          if (ps2_clk_oe) begin
            n = 0;
            while (ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
            seen++;
          end
        end
        n = 0;
        while (!tx_error && n < 2000) begin @(negedge clk); n++; end
        if (tx_error) begin lat = n; oe_ok = !ps2_clk_oe && !ps2_data_oe; end
      end
    join
    repeat (50) @(negedge clk);
    total++; if (seen !== ATTEMPTS) begin bad++; $display("FAIL timeout_attempts: got %0d want %0d", seen, ATTEMPTS); end
    total++; if (lat < TO_CYC_EXP - 5 || lat > TO_CYC_EXP + 12) begin bad++; $display("FAIL timeout_latency: got %0d want about %0d", lat, TO_CYC_EXP); end
    total++; if (oe_ok !== 1'b1) begin bad++; $display("FAIL timeout_lines_released: got %b want 1", oe_ok); end
    total++; if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin bad++; $display("FAIL timeout_counts: got err+%0d done+%0d want +1 +0", err_cnt - e0, done_cnt - d0); end
    total++; if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL timeout_idle: got oe=%b ready=%b want 0 1", ps2_clk_oe, tx_ready); end
  endtask

  task automatic test_nack();
    logic [9:0] bits;
    int inh, d0, e0, frames;
    bit st, seen, acc, gd, ge, ra, quiet;
    d0 = done_cnt; e0 = err_cnt; frames = 0; quiet = 1'b1;
    fork
      send(8'hFF, acc);
      for (int a = 0; a < ATTEMPTS; a++) begin
        dev_frame(1'b0, bits, inh, st, seen);
        if (seen && bits === frame_model(8'hFF)) frames++;
      end
    join
    wait_pulse(gd, ge, ra);
    repeat (100) begin @(negedge clk); if (ps2_clk_oe) quiet = 1'b0; end
    total++; if (frames !== ATTEMPTS) begin bad++; $display("FAIL nack_frames: got %0d want %0d", frames, ATTEMPTS); end
    total++; if ({gd, ge} !== 2'b01) begin bad++; $display("FAIL nack_done/err: got %b want 01", {gd, ge}); end
    total++; if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0 || !quiet) begin bad++; $display("FAIL nack_counts: got err+%0d done+%0d quiet=%b want +1 +0 1", err_cnt - e0, done_cnt - d0, quiet); end
  endtask

`ifdef PS2_TX_RETRY_EN
  task automatic test_retry_ok();
    logic [9:0] b1, b2;
    int i1, i2, d0, e0;
    bit s1, s2, v1, v2, acc, gd, ge, ra;
    d0 = done_cnt; e0 = err_cnt;
    fork
      send(8'hF3, acc);
      begin
        dev_frame(1'b0, b1, i1, s1, v1);
        dev_frame(1'b1, b2, i2, s2, v2);
      end
    join
    wait_pulse(gd, ge, ra);
    total++; if ({v1, v2} !== 2'b11 || b2 !== frame_model(8'hF3)) begin bad++; $display("FAIL retry_frame2: got seen=%b bits=%b want 11 %b", {v1, v2}, b2, frame_model(8'hF3)); end
    total++; if ({gd, ge} !== 2'b10 || (err_cnt - e0) !== 0 || (done_cnt - d0) !== 1) begin bad++; $display("FAIL retry_outcome: got %b err+%0d want 10 +0", {gd, ge}, err_cnt - e0); end
  endtask
`endif

  task automatic test_busy();
    logic [9:0] bits;
    int inh;
    bit acc, busy_ok, st, seen, gd, ge, ra;
    busy_ok = 1'b1;
    dev_data_low = 1'b1;
    repeat (4) @(negedge clk);
    fork
      send(8'h3C, acc);
      begin
        repeat (200) begin @(negedge clk); if (tx_ready || ps2_clk_oe) busy_ok = 1'b0; end
        dev_data_low = 1'b0;
        dev_frame(1'b1, bits, inh, st, seen);
      end
    join
    wait_pulse(gd, ge, ra);
    total++; if (busy_ok !== 1'b1) begin bad++; $display("FAIL busy_hold: got %b want 1", busy_ok); end
    total++; if (bits !== frame_model(8'h3C) || {gd, ge} !== 2'b10) begin bad++; $display("FAIL busy_frame: got %b/%b want %b/10", bits, {gd, ge}, frame_model(8'h3C)); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    bit acc, pre, post_c, post_d;
    d0 = done_cnt; e0 = err_cnt; pre = 1'b0; post_c = 1'b1; post_d = 1'b1;
    fork
      send(8'h00, acc);
      begin
        int n;
        n = 0;
        while (!ps2_clk_oe && n < 20000) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        repeat (3) begin
          dev_clk_low = 1'b1; repeat (H) @(negedge clk);
          dev_clk_low = 1'b0; repeat (H) @(negedge clk);
        end
        pre = ps2_data_oe;
        reset_n = 1'b0;
        @(negedge clk);
        post_c = ps2_clk_oe; post_d = ps2_data_oe;
        @(negedge clk);
        reset_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    total++; if (pre !== 1'b1) begin bad++; $display("FAIL rstmid_data_before: got %b want 1", pre); end
    total++; if ({post_c, post_d} !== 2'b00) begin bad++; $display("FAIL rstmid_oe_after: got %b want 00", {post_c, post_d}); end
    total++; if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0 || tx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_pulses: got done+%0d err+%0d ready=%b want +0 +0 1", done_cnt - d0, err_cnt - e0, tx_ready); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] b1, b2;
    int i1, i2, d0;
    bit s1, s2, v1, v2, gap_ok, got1, gd, ge, ra;
    d0 = done_cnt; gap_ok = 1'b1; got1 = 1'b0;
    fork
      begin
        int n;
        @(negedge clk);
        tx_data = 8'hED; tx_valid = 1'b1; n = 0;
        while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_data = 8'h02; n = 0;
        while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        int n;
        dev_frame(1'b1, b1, i1, s1, v1);
        n = 0;
        while (!tx_done && n < 1000) begin if (ps2_clk_oe) gap_ok = 1'b0; @(negedge clk); n++; end
        got1 = tx_done;
        dev_frame(1'b1, b2, i2, s2, v2);
      end
    join
    wait_pulse(gd, ge, ra);
    total++; if (b1 !== frame_model(8'hED)) begin bad++; $display("FAIL b2b_frame1: got %b want %b", b1, frame_model(8'hED)); end
    total++; if (b2 !== frame_model(8'h02) || i2 !== INH_CYC_EXP) begin bad++; $display("FAIL b2b_frame2: got %b inh=%0d want %b inh=%0d", b2, i2, frame_model(8'h02), INH_CYC_EXP); end
    total++; if ({got1, gap_ok} !== 2'b11) begin bad++; $display("FAIL b2b_order: got done1/gap=%b want 11", {got1, gap_ok}); end
    total++; if ((done_cnt - d0) !== 2 || {gd, ge} !== 2'b10) begin bad++; $display("FAIL b2b_counts: got done+%0d want +2", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_frame(8'hED, "byte_ED");
    test_frame(8'h00, "byte_00");
    test_frame(8'h01, "byte_01");
    for (int k = 0; k < 3; k++) test_frame(8'($urandom_range(0, 255)), "byte_rand");
    test_timeout();
    test_nack();
`ifdef PS2_TX_RETRY_EN
    test_retry_ok();
`endif
    test_busy();
    test_reset_mid();
    test_back_to_back();
    total++; if (excl_bad !== 0) begin bad++; $display("FAIL pulse_exclusive: got %0d violations want 0", excl_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
